// File: rtl/alu_arbiter.sv
// Two-requester front-end for a shared ALU: arbitrates, registers operands onto the
// ALU inputs, captures result/zero and returns them on one ID-tagged response channel.
//
// state | meaning
// IDLE  | waiting for a request; grant computed from valids, granted side sees ready
// ISSUE | registered operands are on the ALU; result captured at end of cycle
// RESP  | response held on rsp_* until rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int FAIR  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src1,
    input  logic [WIDTH-1:0] req0_src2,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src1,
    input  logic [WIDTH-1:0] req1_src2,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   grant1;
    logic   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        grant1     = 1'b0;
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        // On a tie, round-robin hands the grant to whoever did not win last time.
        if (req0_valid && req1_valid) grant1 = (FAIR != 0) ? ~last_grant : 1'b0;
        else                          grant1 = req1_valid;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = ~grant1;
                    req1_ready = grant1;
                    accept     = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_control <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_id      <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            if (accept) begin
                alu_src1    <= grant1 ? req1_src1 : req0_src1;
                alu_src2    <= grant1 ? req1_src2 : req0_src2;
                alu_control <= grant1 ? req1_op   : req0_op;
                rsp_id      <= grant1;
                last_grant  <= grant1;
            end
            if (state == ISSUE) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_valid  <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing front-end that shares the single RV32 `alu` instance (src1, src2, 3-bit alu_control → result, zero) between two independent requesters, for example the execute stage and a branch/address helper. It arbitrates, registers the granted operands onto the ALU inputs, and captures result/zero. It returns them on a single response channel tagged with the requester ID. Only one operation is outstanding at a time.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `OPW`, default 3: width of alu_control. Passed through unmodified.
- `FAIR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  requester has an operation pending.
- `req0_ready`, `req1_ready`  out  1 each  operation accepted on this edge when valid & ready.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2`  in  WIDTH each  operands.
- `req0_op`, `req1_op`  in  OPW each  ALU control code.
- `alu_src1`, `alu_src2`  out  WIDTH  registered operands driven to the ALU.
- `alu_control`  out  OPW  registered control code driven to the ALU.
- `alu_result`  in  WIDTH  ALU result (combinational from the ALU inputs).
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_id`  out  1  requester that issued the operation (0 or 1).

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant is computed combinationally from the valids.
  - Only the granted requester sees ready=1.
  - On the handshake, latch src1/src2/op into alu_src1/alu_src2/alu_control, latch the ID, and go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - The ALU evaluates the registered operands.
  - At the end of the cycle, capture alu_result into rsp_result and alu_zero into rsp_zero. Set rsp_valid and go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_valid & rsp_ready: clear rsp_valid and return to IDLE.
- Both ready outputs are 0 in ISSUE and RESP.
- Arbitration with FAIR=1:
  - A last_grant bit records the winner of each handshake.
  - When both requesters are valid, the grant goes to the requester other than last_grant.
  - When only one is valid, that one is granted regardless of last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Arbitration with FAIR=0: requester 0 always wins a tie.
- A request that is not granted must hold its valid and payload until it is accepted. The block never drops an unaccepted request.
- The ALU drive registers change only on an accept edge; between operations they hold the last operands.
- Width rules: operands and result pass through at WIDTH bits. The block does no arithmetic. Op codes are not decoded.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0.
  - alu_src1=0, alu_src2=0, alu_control=0, last_grant=1.
  - req0_ready=req1_ready=0 while rst_n=0.
- Latency: accept on edge N. The ALU inputs are updated after edge N. rsp_valid=1 after edge N+1. The response is therefore visible 2 cycles after the accept edge.
- Throughput: with rsp_ready held at 1, at most one operation every 3 cycles (IDLE→ISSUE→RESP→IDLE).
- Back-pressure: each cycle of rsp_ready=0 in RESP adds one cycle. Both requesters stall during that time.
- Simultaneous events:
  - Both valids asserted in IDLE: exactly one ready is asserted.
  - The loser's valid stays high and it is served on the next IDLE visit.
- Reset mid-operation: the in-flight operation and any pending response are discarded. All outputs return to their reset values immediately. No response is produced for the discarded operation.

## Test plan
- Single op: req0 sends 100, 20, op=000 → req0_ready=1 on the accept cycle. Two cycles later: rsp_valid=1, rsp_result=120, rsp_zero=0, rsp_id=0.
- Zero flag: req1 sends 15, 15, op=001 → rsp_result=0, rsp_zero=1, rsp_id=1. Before the response, alu_control=001, alu_src1=15 and alu_src2=15.
- Contention, FAIR=1:
  - Setup: both requesters held valid from reset. req0 sends 30, 10, op=010; req1 sends 100, 20, op=000.
  - Required responses, in order: rsp_id=0 (result=30 op 010 as computed by the ALU), then rsp_id=1 (result=120), then rsp_id=0 again. The grants alternate.
- Fixed priority: FAIR=0, both requesters valid continuously → every response has rsp_id=0 and req1_ready never rises.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_result, rsp_zero and rsp_id are stable, both ready outputs stay 0. The response completes on the first cycle with rsp_ready=1.
- Reset mid-op: assert rst_n=0 during ISSUE → rsp_valid=0 and all alu_* outputs are 0 immediately. After release, a new req0 sends 5, 3, op=000 and gets rsp_result=8.
